// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 16x-oversampled UART receiver that packs FRAME_BYTES bytes into one block with valid/ack.
// Define UART_RX_PARITY_EN for 8E1 framing and a parity_err output; the default build is 8N1.
module uart_frame_rx #(
    parameter int CLKS_PER_TICK = 27,
    parameter int OVERSAMPLE    = 16,
    parameter int FRAME_BYTES   = 16,
    parameter int TIMEOUT_BITS  = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rx_in,
    input  logic                             en,
    output logic [8*FRAME_BYTES-1:0]         frame_data,
    output logic                             frame_valid,
    input  logic                             frame_ack,
    output logic [$clog2(FRAME_BYTES+1)-1:0] byte_cnt,
    output logic                             framing_err,
    output logic                             timeout_err,
`ifdef UART_RX_PARITY_EN
    output logic                             parity_err,
`endif
    output logic                             overrun_err
);

    localparam int CNT_W    = $clog2(FRAME_BYTES + 1);
    localparam int TICK_W   = $clog2(CLKS_PER_TICK);
    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam int FRAME_W  = 8 * FRAME_BYTES;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_e;

    state_e             state_q;
    logic               rx_meta_q;
    logic               rx_sync_q;
    logic               rx_prev_q;
    logic [TICK_W-1:0]  tick_cnt_q;
    logic [OS_W-1:0]    os_cnt_q;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         shift_q;
    logic [FRAME_W-1:0] frame_sr_q;
    logic [FRAME_W-1:0] frame_data_q;
    logic               frame_valid_q;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [TO_W-1:0]    idle_cnt_q;
    logic               framing_err_q;
    logic               timeout_err_q;
    logic               overrun_err_q;
`ifdef UART_RX_PARITY_EN
    logic               parity_err_q;
    logic               par_bad_q;
`endif

    logic tick_d;
    logic start_det_d;
    logic sample_d;
    logic idle_count_d;
    logic timeout_d;
    logic frame_full_d;

    // START samples at mid-bit; every later state samples one full bit-time after the previous sample.
    always_comb begin
        tick_d      = (tick_cnt_q == TICK_W'(CLKS_PER_TICK - 1));
        start_det_d = en && (state_q == IDLE) && rx_prev_q && !rx_sync_q;
        sample_d    = 1'b0;
        if (tick_d) begin
            if (state_q == START) begin
                sample_d = (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));
            end else begin
                sample_d = (os_cnt_q == OS_W'(OVERSAMPLE - 1));
            end
        end
        frame_full_d = (byte_cnt_q == CNT_W'(FRAME_BYTES));
        idle_count_d = en && (state_q == IDLE) && (byte_cnt_q != '0)
                       && !frame_full_d && !start_det_d;
        timeout_d    = idle_count_d && tick_d && (idle_cnt_q == TO_W'(TO_LIMIT - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Restarting the tick counter on the start edge phase-aligns every sample to that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
        end else if (start_det_d || tick_d) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= '0;
        end else if (!idle_count_d || timeout_d) begin
            idle_cnt_q <= '0;
        end else if (tick_d) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            os_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            frame_sr_q    <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            byte_cnt_q    <= '0;
            framing_err_q <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= 1'b0;
            par_bad_q     <= 1'b0;
`endif
        end else begin
            framing_err_q <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= 1'b0;
`endif

            // An ack on the completion edge frees the output register, so the new frame wins.
            if (frame_valid_q && frame_ack) begin
                frame_valid_q <= 1'b0;
            end
            if (frame_full_d) begin
                byte_cnt_q <= '0;
                if (!frame_valid_q || frame_ack) begin
                    frame_data_q  <= frame_sr_q;
                    frame_valid_q <= 1'b1;
                end else begin
                    overrun_err_q <= 1'b1;
                end
            end

            if (tick_d && (state_q != IDLE)) begin
                os_cnt_q <= sample_d ? '0 : os_cnt_q + 1'b1;
            end

            if (!en) begin
                state_q    <= IDLE;
                byte_cnt_q <= '0;
            end else begin
                if (timeout_d) begin
                    timeout_err_q <= 1'b1;
                    byte_cnt_q    <= '0;
                end
                case (state_q)
                    IDLE: begin
                        if (start_det_d) begin
                            state_q  <= START;
                            os_cnt_q <= '0;
                        end
                    end
                    START: begin
                        bit_cnt_q <= '0;
                        if (sample_d) begin
                            state_q <= rx_sync_q ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        if (sample_d) begin
                            shift_q   <= {rx_sync_q, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (sample_d) begin
                            par_bad_q    <= (^shift_q) != rx_sync_q;
                            parity_err_q <= (^shift_q) != rx_sync_q;
                            state_q      <= STOP;
                        end
                    end
`endif
                    STOP: begin
                        if (sample_d) begin
                            if (!rx_sync_q) begin
                                framing_err_q <= 1'b1;
                                state_q       <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad_q) begin
                                state_q <= IDLE;
`endif
                            end else begin
                                frame_sr_q <= {frame_sr_q[FRAME_W-9:0], shift_q};
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                                state_q    <= IDLE;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx_sync_q) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign byte_cnt    = byte_cnt_q;
    assign framing_err = framing_err_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed bench for uart_frame_rx with CLKS_PER_TICK=4, so one UART bit is 64 clk.
module tb_uart_frame_rx;

    localparam int BIT_CLKS = 64;

    logic         clk;
    logic         reset;
    logic         rxIn;
    logic         en;
    logic         frameAck;
    logic [127:0] frameData;
    logic         frameValid;
    logic [4:0]   byteCnt;
    logic         framingErr;
    logic         timeoutErr;
    logic         overrunErr;

    int nCompared   = 0;
    int nMismatched = 0;
    int framingCnt  = 0;
    int timeoutCnt  = 0;
    int overrunCnt  = 0;

    logic [127:0] blockA = 128'hDEADBEEFCAFEBABE1234567890ABCDEF;
    logic [127:0] blockB = 128'h00112233445566778899AABBCCDDEEFF;
    logic [127:0] blockC = 128'h000102030405060708090A0B0C0D0E0F;

    uart_frame_rx #(
        .CLKS_PER_TICK(4),
        .OVERSAMPLE   (16),
        .FRAME_BYTES  (16),
        .TIMEOUT_BITS (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rxIn),
        .en         (en),
        .frame_data (frameData),
        .frame_valid(frameValid),
        .frame_ack  (frameAck),
        .byte_cnt   (byteCnt),
        .framing_err(framingErr),
        .timeout_err(timeoutErr),
        .overrun_err(overrunErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each error pulse should be counted exactly once; a stuck flag inflates these counts.
    always @(negedge clk) begin
        if (reset) begin
            if (framingErr) framingCnt++;
            if (timeoutErr) timeoutCnt++;
            if (overrunErr) overrunCnt++;
        end
    end

    task automatic sendHead(input logic [7:0] b);
        @(negedge clk);
        rxIn = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxIn = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        sendHead(b);
        rxIn = stopBit;
        repeat (BIT_CLKS) @(negedge clk);
        rxIn = 1'b1;
        if (!stopBit) repeat (16) @(negedge clk);
    endtask

    task automatic sendBlock(input logic [127:0] blk, input int count);
        for (int i = 0; i < count; i++) begin
            sendByte(blk[127-8*i -: 8], 1'b1);
        end
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        rxIn     = 1'b1;
        en       = 1'b1;
        frameAck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nCompared++;
        if (frameValid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_valid: got %0b want 0", frameValid);
        end
        nCompared++;
        if (frameData !== 128'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_data: got %h want 0", frameData);
        end
        nCompared++;
        if (byteCnt !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_cnt: got %0d want 0", byteCnt);
        end
        nCompared++;
        if ({framingErr, timeoutErr, overrunErr} !== 3'b000) begin
            nMismatched++;
            $display("[TB] FAIL reset_errs: got %b want 000", {framingErr, timeoutErr, overrunErr});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_full_frame;
        sendBlock(blockA, 15);
        nCompared++;
        if (byteCnt !== 5'd15) begin
            nMismatched++;
            $display("[TB] FAIL full_cnt15: got %0d want 15", byteCnt);
        end
        sendHead(blockA[7:0]);
        rxIn = 1'b1;
        // Stop sample lands on the 35th rising edge after the stop bit starts; the frame loads on the next.
        repeat (35) @(posedge clk);
        #1;
        nCompared++;
        if (byteCnt !== 5'd16 || frameValid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL full_pre_load: got cnt=%0d valid=%0b want cnt=16 valid=0", byteCnt, frameValid);
        end
        @(posedge clk);
        #1;
        nCompared++;
        if (frameValid !== 1'b1 || byteCnt !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL full_load: got valid=%0b cnt=%0d want valid=1 cnt=0", frameValid, byteCnt);
        end
        nCompared++;
        if (frameData !== blockA) begin
            nMismatched++;
            $display("[TB] FAIL full_data: got %h want %h", frameData, blockA);
        end
        @(negedge clk);
        repeat (28) @(negedge clk);
        nCompared++;
        if (framingCnt != 0 || timeoutCnt != 0 || overrunCnt != 0) begin
            nMismatched++;
            $display("[TB] FAIL full_no_errs: got %0d/%0d/%0d want 0/0/0", framingCnt, timeoutCnt, overrunCnt);
        end
    endtask

    task automatic test_overrun;
        sendBlock(blockC, 16);
        repeat (4) @(negedge clk);
        nCompared++;
        if (overrunCnt != 1) begin
            nMismatched++;
            $display("[TB] FAIL overrun_count: got %0d want 1", overrunCnt);
        end
        nCompared++;
        if (frameData !== blockA || frameValid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL overrun_hold: got %h valid=%0b want %h valid=1", frameData, frameValid, blockA);
        end
        nCompared++;
        if (byteCnt !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL overrun_cnt: got %0d want 0", byteCnt);
        end
        @(negedge clk);
        frameAck = 1'b1;
        #1;
        nCompared++;
        if (frameValid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL ack_early: got %0b want 1", frameValid);
        end
        @(posedge clk);
        #1;
        nCompared++;
        if (frameValid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL ack_clear: got %0b want 0", frameValid);
        end
        @(negedge clk);
        frameAck = 1'b0;
    endtask

    task automatic test_framing;
        sendByte(8'h55, 1'b0);
        nCompared++;
        if (framingCnt != 1 || byteCnt !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL framing_pulse: got cnt=%0d bytes=%0d want 1 and 0", framingCnt, byteCnt);
        end
        sendBlock(blockB, 16);
        repeat (4) @(negedge clk);
        nCompared++;
        if (frameValid !== 1'b1 || frameData !== blockB) begin
            nMismatched++;
            $display("[TB] FAIL framing_frame: got %h valid=%0b want %h valid=1", frameData, frameValid, blockB);
        end
        nCompared++;
        if (framingCnt != 1 || overrunCnt != 1) begin
            nMismatched++;
            $display("[TB] FAIL framing_errs: got framing=%0d overrun=%0d want 1 and 1", framingCnt, overrunCnt);
        end
        @(negedge clk);
        frameAck = 1'b1;
        @(negedge clk);
        frameAck = 1'b0;
        nCompared++;
        if (frameValid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL framing_ack: got %0b want 0", frameValid);
        end
    endtask

    task automatic test_timeout;
        sendBlock(blockC, 5);
        nCompared++;
        if (byteCnt !== 5'd5) begin
            nMismatched++;
            $display("[TB] FAIL timeout_cnt5: got %0d want 5", byteCnt);
        end
        repeat (31 * BIT_CLKS) @(negedge clk);
        nCompared++;
        if (timeoutCnt != 0 || byteCnt !== 5'd5) begin
            nMismatched++;
            $display("[TB] FAIL timeout_early: got pulses=%0d bytes=%0d want 0 and 5", timeoutCnt, byteCnt);
        end
        repeat (BIT_CLKS + 4) @(negedge clk);
        nCompared++;
        if (timeoutCnt != 1 || byteCnt !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL timeout_fire: got pulses=%0d bytes=%0d want 1 and 0", timeoutCnt, byteCnt);
        end
        sendBlock(blockA, 16);
        repeat (4) @(negedge clk);
        nCompared++;
        if (frameValid !== 1'b1 || frameData !== blockA) begin
            nMismatched++;
            $display("[TB] FAIL timeout_after: got %h valid=%0b want %h valid=1", frameData, frameValid, blockA);
        end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        rxIn = 1'b0;
        repeat (3) @(negedge clk);
        rxIn = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        nCompared++;
        if (framingCnt != 1 || timeoutCnt != 1 || byteCnt !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL glitch_quiet: got framing=%0d timeout=%0d bytes=%0d want 1 1 0",
                     framingCnt, timeoutCnt, byteCnt);
        end
        sendByte(8'hA5, 1'b1);
        nCompared++;
        if (byteCnt !== 5'd1) begin
            nMismatched++;
            $display("[TB] FAIL glitch_recover: got %0d want 1", byteCnt);
        end
    endtask

    task automatic test_reset_mid;
        sendBlock(blockC, 8);
        nCompared++;
        if (byteCnt !== 5'd9 || frameValid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL mid_pre: got bytes=%0d valid=%0b want 9 and 1", byteCnt, frameValid);
        end
        @(negedge clk);
        rxIn = 1'b0;
        repeat (3 * BIT_CLKS + 10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        nCompared++;
        if (frameValid !== 1'b0 || frameData !== 128'h0 || byteCnt !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL mid_async: got valid=%0b data=%h bytes=%0d want all 0", frameValid, frameData, byteCnt);
        end
        rxIn = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        sendBlock(blockB, 16);
        repeat (4) @(negedge clk);
        nCompared++;
        if (frameValid !== 1'b1 || frameData !== blockB) begin
            nMismatched++;
            $display("[TB] FAIL mid_after: got %h valid=%0b want %h valid=1", frameData, frameValid, blockB);
        end
        nCompared++;
        if (framingCnt != 1 || timeoutCnt != 1 || overrunCnt != 1) begin
            nMismatched++;
            $display("[TB] FAIL mid_errs: got %0d/%0d/%0d want 1/1/1", framingCnt, timeoutCnt, overrunCnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_overrun();
        test_framing();
        test_timeout();
        test_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Receive-side counterpart of the AES-over-UART transmit path. Deserialises an 8-bit UART stream (LSB first, 1 stop bit, 16x oversampled) into bytes, then assembles 16 consecutive bytes into one 128-bit cipher block. The block is presented to the downstream decipher/CRC-check stage with a valid/ack handshake. Line errors, inter-byte timeouts and frame overruns are flagged.

Parameters:
CLKS_PER_TICK, 27, clk cycles per oversample tick (50 MHz / 115200 / 16); legal range 2 or more.
OVERSAMPLE, 16, ticks per bit; fixed even value, mid-bit sample at tick OVERSAMPLE/2-1.
FRAME_BYTES, 16, bytes per frame; frame_data width = 8*FRAME_BYTES.
TIMEOUT_BITS, 32, idle bit-times allowed between bytes of a partial frame.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
rx_in  input  1  serial line, idle high, asynchronous to clk.
en  input  1  receive enable; 0 holds the FSM in IDLE and clears byte_cnt.
frame_data  output  8*FRAME_BYTES  assembled frame; first received byte in bits [8*FRAME_BYTES-1 -: 8].
frame_valid  output  1  frame_data holds a complete, unacknowledged frame.
frame_ack  input  1  consumer accept; sampled only while frame_valid=1.
byte_cnt  output  $clog2(FRAME_BYTES+1)  good bytes held in the current partial frame.
framing_err  output  1  one-cycle pulse: stop bit sampled low.
timeout_err  output  1  one-cycle pulse: partial frame discarded on timeout.
overrun_err  output  1  one-cycle pulse: a frame completed while frame_valid=1.

Behaviour:
- Reset (reset=0, async): all outputs 0, frame_data=0, FSM=IDLE, all counters 0, synchroniser flops=1.
- rx_in passes through a 2-flop synchroniser. All sampling uses the synchronised value, so there are 2 clk of latency.
- The tick strobe is generated from a free-running counter 0..CLKS_PER_TICK-1. It is reset to 0 when a start edge is detected, so sampling phase aligns to the edge.
- FSM states and transitions:
  - IDLE: on a synced falling edge with en=1, go to START and clear the tick counter.
  - START: at mid-bit tick (OVERSAMPLE/2-1), if the line is 0, go to DATA. If it is 1 (glitch), return to IDLE with no error.
  - DATA: sample every OVERSAMPLE ticks after the mid-start sample. Shift into the byte register LSB first. After 8 bits, go to PARITY if enabled, otherwise STOP.
  - STOP: at mid-stop sample:
    - Line 1: byte is good. Write it into the frame shift register, increment byte_cnt, go to IDLE.
    - Line 0: pulse framing_err, discard the byte (byte_cnt unchanged), go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synced line is 1, then go to IDLE.
- Frame assembly:
  - Good bytes shift in at the low end, so byte 0 ends in the MSBs.
  - When byte_cnt reaches FRAME_BYTES and frame_valid=0: on the next clk, copy to frame_data, set frame_valid=1 and clear byte_cnt. Latency is 1 clk after the final stop-bit sample.
  - When byte_cnt reaches FRAME_BYTES and frame_valid=1: pulse overrun_err, drop the new frame, clear byte_cnt, leave frame_data unchanged.
- Handshake:
  - frame_valid=1 and frame_ack=1 on a clk edge clears frame_valid next cycle.
  - frame_data is held stable while frame_valid=1.
  - If ack coincides with a new frame completion, the ack is applied first. The new frame loads and frame_valid stays 1, with no overrun.
- Timeout:
  - An idle counter counts ticks in IDLE while byte_cnt is nonzero.
  - At TIMEOUT_BITS*OVERSAMPLE ticks: pulse timeout_err and clear byte_cnt.
  - The counter clears on any start detection or when byte_cnt is 0.
- en=0 mid-byte: abort to IDLE next clk, clear byte_cnt, no error pulse. frame_valid and frame_data are unaffected.
- Error pulses are exactly 1 clk wide. Simultaneous error causes each raise their own flag.

Optional Feature:
UART_RX_PARITY_EN.
- Defined: an even-parity bit is expected after D7, in the PARITY state, sampled at its mid-bit. Adds output parity_err (1-cycle pulse) on mismatch. A byte with a parity error is discarded, but the stop bit is still checked.
- Undefined: there is no PARITY state and no parity_err port. The frame is 8N1.

Test Plan:
- Use CLKS_PER_TICK=4. Send the 16 bytes DE AD BE EF CA FE BA BE 12 34 56 78 90 AB CD EF, no ack. Required: frame_data = 128'hDEADBEEFCAFEBABE1234567890ABCDEF, frame_valid=1 one clk after the last stop sample, byte_cnt=0.
- Hold frame_ack low and send a second full frame. Required: overrun_err pulses once and frame_data is unchanged. Then pulse frame_ack: frame_valid falls next clk.
- Send byte 0x55 with the stop bit forced 0, then 16 good bytes. Required: framing_err pulses once and the 0x55 is absent from the frame.
- Send 5 bytes, then idle 32 bit-times plus one tick. Required: timeout_err pulses and byte_cnt drops 5→0. A following 16-byte frame is received correctly.
- Apply a 3-clk low glitch on rx_in (shorter than half a bit). Required: no state change beyond START, no error, byte_cnt unchanged.
- Assert reset low mid-byte 9. Required: all outputs go to 0 immediately and asynchronously. After release, a full frame is received correctly.
